// File: rtl/svc_axi_mem.sv
// AXI4 subordinate backed by an internal word memory with zero wait states.
// Write and read engines are independent, with one outstanding burst each.
module svc_axi_mem #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,

    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,

    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,

    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,

    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = (STRB_WIDTH > 1) ? $clog2(STRB_WIDTH) : 0;
    localparam int MEM_DEPTH  = 1 << MEM_ADDR_WIDTH;

    localparam logic [2:0] FULL_SIZE   = 3'(BYTE_SHIFT);
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_STEP = MEM_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_BURST}        r_state_t;

    // Upper byte-address bits are ignored so the memory aliases across the map.
    logic [MEM_ADDR_WIDTH-1:0] aw_word;
    logic [MEM_ADDR_WIDTH-1:0] ar_word;
    logic                      aw_legal;
    logic                      ar_legal;
    logic                      unused_addr_bits;

    assign aw_word  = s_axi_awaddr[BYTE_SHIFT +: MEM_ADDR_WIDTH];
    assign ar_word  = s_axi_araddr[BYTE_SHIFT +: MEM_ADDR_WIDTH];
    assign aw_legal = ((s_axi_awburst == BURST_FIXED) || (s_axi_awburst == BURST_INCR)) &&
                      (s_axi_awsize == FULL_SIZE);
    assign ar_legal = ((s_axi_arburst == BURST_FIXED) || (s_axi_arburst == BURST_INCR)) &&
                      (s_axi_arsize == FULL_SIZE);
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    w_state_t                  w_state_q, w_state_d;
    logic [AXI_ID_WIDTH-1:0]   w_id_q, w_id_d;
    logic [MEM_ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [7:0]                w_len_q, w_len_d;
    logic [7:0]                w_cnt_q, w_cnt_d;
    logic                      w_fixed_q, w_fixed_d;
    logic                      w_bad_q, w_bad_d;
    logic                      w_err_q, w_err_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic                      w_last_beat;
    logic                      mem_we;

    assign w_last_beat = (w_cnt_q == w_len_q);

    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_bad_d   = w_bad_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi_awvalid && awready_q) begin
                    w_id_d    = s_axi_awid;
                    w_addr_d  = aw_word;
                    w_len_d   = s_axi_awlen;
                    w_cnt_d   = 8'd0;
                    w_fixed_d = (s_axi_awburst == BURST_FIXED);
                    w_bad_d   = !aw_legal;
                    w_err_d   = !aw_legal;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s_axi_wvalid && wready_q) begin
                    // Illegal bursts still consume every beat, they just never reach memory.
                    mem_we  = !w_bad_q;
                    w_cnt_d = w_cnt_q + 8'd1;
                    if (s_axi_wlast != w_last_beat) begin
                        w_err_d = 1'b1;
                    end
                    if (!w_fixed_q) begin
                        w_addr_d = w_addr_q + ADDR_STEP;
                    end
                    if (w_last_beat) begin
                        w_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_bad_q   <= 1'b0;
            w_err_q   <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_bad_q   <= w_bad_d;
            w_err_q   <= w_err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_addr_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = w_id_q;
    assign s_axi_bresp   = (bvalid_q && w_err_q) ? RESP_SLVERR : RESP_OKAY;

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    r_state_t                  r_state_q, r_state_d;
    logic [AXI_ID_WIDTH-1:0]   r_id_q, r_id_d;
    logic [MEM_ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [7:0]                r_len_q, r_len_d;
    logic [7:0]                r_cnt_q, r_cnt_d;
    logic                      r_fixed_q, r_fixed_d;
    logic                      r_bad_q, r_bad_d;
    logic                      r_more_q, r_more_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic                      rlast_q, rlast_d;
    logic [AXI_ID_WIDTH-1:0]   rid_q, rid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Beat source: the AR channel itself for beat 0, the latched burst afterwards.
    logic                      r_issue;
    logic [MEM_ADDR_WIDTH-1:0] iss_addr;
    logic [7:0]                iss_idx;
    logic [7:0]                iss_len;
    logic                      iss_fixed;
    logic                      iss_bad;
    logic [AXI_ID_WIDTH-1:0]   iss_id;
    logic [AXI_DATA_WIDTH-1:0] mem_rd;
    logic                      ar_hs;
    logic                      r_hs;

    assign ar_hs = s_axi_arvalid && arready_q;
    assign r_hs  = rvalid_q && s_axi_rready;

    always_comb begin
        r_issue   = 1'b0;
        iss_addr  = r_addr_q;
        iss_idx   = r_cnt_q;
        iss_len   = r_len_q;
        iss_fixed = r_fixed_q;
        iss_bad   = r_bad_q;
        iss_id    = r_id_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    r_issue   = 1'b1;
                    iss_addr  = ar_word;
                    iss_idx   = 8'd0;
                    iss_len   = s_axi_arlen;
                    iss_fixed = (s_axi_arburst == BURST_FIXED);
                    iss_bad   = !ar_legal;
                    iss_id    = s_axi_arid;
                end
            end
            R_BURST: begin
                r_issue = r_more_q && (!rvalid_q || s_axi_rready);
            end
            default: r_issue = 1'b0;
        endcase
    end

    assign mem_rd = mem[iss_addr];

    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_fixed_d = r_fixed_q;
        r_bad_d   = r_bad_q;
        r_more_d  = r_more_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (r_state_q == R_IDLE && ar_hs) begin
            r_id_d    = iss_id;
            r_len_d   = iss_len;
            r_fixed_d = iss_fixed;
            r_bad_d   = iss_bad;
            r_state_d = R_BURST;
        end
        if (r_issue) begin
            rvalid_d = 1'b1;
            rdata_d  = iss_bad ? '0 : mem_rd;
            rlast_d  = (iss_idx == iss_len);
            rid_d    = iss_id;
            rresp_d  = iss_bad ? RESP_SLVERR : RESP_OKAY;
            r_more_d = (iss_idx != iss_len);
            r_addr_d = iss_fixed ? iss_addr : iss_addr + ADDR_STEP;
            r_cnt_d  = iss_idx + 8'd1;
        end else if (r_state_q == R_BURST && r_hs) begin
            // Nothing left to issue, so the accepted beat was the final one.
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            if (!r_more_q) begin
                r_state_d = R_IDLE;
            end
        end
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            r_bad_q   <= 1'b0;
            r_more_q  <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            r_bad_q   <= r_bad_d;
            r_more_q  <= r_more_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

endmodule

// File: tb/tb_svc_axi_mem.sv
// Self-checking bench for svc_axi_mem: directed vectors, corner sequences and
// randomized bursts scored against a plain array model of the memory.
module tb_svc_axi_mem;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        awvalid = 0, awready;
    logic [15:0] awaddr = 0;
    logic [3:0]  awid = 0;
    logic [7:0]  awlen = 0;
    logic [2:0]  awsize = 0;
    logic [1:0]  awburst = 0;
    logic        wvalid = 0, wready, wlast = 0;
    logic [15:0] wdata = 0;
    logic [1:0]  wstrb = 0;
    logic        bvalid, bready = 0;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        arvalid = 0, arready;
    logic [15:0] araddr = 0;
    logic [3:0]  arid = 0;
    logic [7:0]  arlen = 0;
    logic [2:0]  arsize = 0;
    logic [1:0]  arburst = 0;
    logic        rvalid, rready = 0, rlast;
    logic [3:0]  rid;
    logic [15:0] rdata;
    logic [1:0]  rresp;

    always #5 clk = ~clk;

    svc_axi_mem dut (
        .clk(clk), .rst(rst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_awid(awid), .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata),
        .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_arid(arid), .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rid(rid), .s_axi_rdata(rdata),
        .s_axi_rresp(rresp), .s_axi_rlast(rlast)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the memory as a plain array of words.
    logic [15:0] model_mem [DEPTH];
    logic [15:0] wbuf [256];
    logic [1:0]  sbuf [256];
    logic [15:0] rbuf [256];
    int          rcycles;
    logic [1:0]  last_rresp;
    int          b_delay = 0;

    function automatic bit wlast_for(input int i, input int len, input int mode);
        if (mode == 0) return (i == len);
        if (mode == 1) return (i == 0);
        return 1'b0;
    endfunction

    function automatic bit is_legal(input logic [1:0] burst, input logic [2:0] size);
        return (burst == 2'b00 || burst == 2'b01) && size == 3'd1;
    endfunction

    function automatic logic [1:0] model_write(input logic [15:0] addr, input int len,
                                               input logic [2:0] size, input logic [1:0] burst,
                                               input int mode);
        bit legal = is_legal(burst, size);
        bit err   = !legal;
        int w     = int'(addr >> 1) % DEPTH;
        for (int i = 0; i <= len; i++) begin
            if (wlast_for(i, len, mode) != (i == len)) err = 1'b1;
            if (legal) begin
                if (sbuf[i][0]) model_mem[w][7:0]  = wbuf[i][7:0];
                if (sbuf[i][1]) model_mem[w][15:8] = wbuf[i][15:8];
                if (burst == 2'b01) w = (w + 1) % DEPTH;
            end
        end
        return err ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] addr, input logic [1:0] burst,
                                               input logic [2:0] size, input int beat);
        if (!is_legal(burst, size)) return 16'h0000;
        return model_mem[(int'(addr >> 1) + ((burst == 2'b01) ? beat : 0)) % DEPTH];
    endfunction

    task automatic do_write(input logic [15:0] addr, input logic [3:0] id, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode,
                            output logic [1:0] resp);
        int n;
        logic [1:0] exp;
        @(negedge clk);
        awaddr = addr; awid = id; awlen = 8'(len); awsize = size; awburst = burst;
        awvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(negedge clk); n++; end
        check("aw_accept", 32'(n < 50), 32'd1);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = wbuf[i]; wstrb = sbuf[i]; wlast = wlast_for(i, len, mode);
            n = 0;
            while (!wready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) check("w_accept", 32'(n), 32'd0);
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clk); n++; end
        check("b_valid", 32'(bvalid), 32'd1);
        resp = bresp;
        for (int k = 0; k < b_delay; k++) begin
            @(negedge clk);
            check("b_hold", {bvalid, bresp}, {1'b1, resp});
        end
        check("bid", 32'(bid), 32'(id));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("b_drop", 32'(bvalid), 32'd0);
        check("aw_ready_again", 32'(awready), 32'd1);
        exp = model_write(addr, len, size, burst, mode);
        check("bresp", 32'(resp), 32'(exp));
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [3:0] id, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int rmode);
        int n, beat, cyc, first, last;
        bit stalled;
        logic [15:0] prev_data;
        logic prev_last;
        int extra;
        @(negedge clk);
        araddr = addr; arid = id; arlen = 8'(len); arsize = size; arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        check("ar_accept", 32'(n < 50), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("rvalid_latency", 32'(rvalid), 32'd1);
        beat = 0; cyc = 0; first = 0; last = 0; stalled = 0;
        prev_data = '0; prev_last = 0;
        while (beat <= len && cyc < 2000) begin
            rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            if (stalled && rvalid) check("r_stable", {rdata, rlast}, {prev_data, prev_last});
            stalled = 0;
            if (rvalid && rready) begin
                check("rdata", 32'(rdata), 32'(model_read(addr, burst, size, beat)));
                check("rlast", 32'(rlast), 32'(beat == len));
                check("rresp", 32'(rresp), is_legal(burst, size) ? 32'd0 : 32'd2);
                check("rid", 32'(rid), 32'(id));
                rbuf[beat] = rdata;
                last_rresp = rresp;
                if (beat == 0) first = cyc;
                last = cyc;
                beat++;
            end else if (rvalid) begin
                stalled = 1; prev_data = rdata; prev_last = rlast;
            end
            @(negedge clk);
            cyc++;
        end
        check("r_beats", 32'(beat), 32'(len + 1));
        rcycles = last - first + 1;
        rready = 1'b1;
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            if (rvalid) extra++;
            @(negedge clk);
        end
        check("r_no_extra", 32'(extra), 32'd0);
        rready = 1'b0;
    endtask

    typedef struct {
        logic [1:0] burst;
        logic [2:0] size;
        int         len;
        int         mode;
        logic [1:0] exp_bresp;
        logic [1:0] exp_rresp;
        bit         written;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp;
        logic [15:0] addr, old;
        int          w, n, extra;

        vecs[0] = '{2'b00, 3'd1, 0, 0, 2'b00, 2'b00, 1'b1};
        vecs[1] = '{2'b01, 3'd1, 3, 0, 2'b00, 2'b00, 1'b1};
        vecs[2] = '{2'b10, 3'd1, 1, 0, 2'b10, 2'b10, 1'b0};
        vecs[3] = '{2'b11, 3'd1, 0, 0, 2'b10, 2'b10, 1'b0};
        vecs[4] = '{2'b01, 3'd0, 1, 0, 2'b10, 2'b10, 1'b0};
        vecs[5] = '{2'b01, 3'd2, 0, 0, 2'b10, 2'b10, 1'b0};
        vecs[6] = '{2'b01, 3'd1, 1, 1, 2'b10, 2'b00, 1'b1};
        vecs[7] = '{2'b01, 3'd1, 2, 2, 2'b10, 2'b00, 1'b1};
        vecs[8] = '{2'b00, 3'd1, 2, 0, 2'b00, 2'b00, 1'b1};

        // Reset state and release
        #12;
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_valids", {bvalid, rvalid, wready}, 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_ready", {awready, arready, wready, bvalid, rvalid}, 32'b11000);
        repeat (5) @(negedge clk);
        check("rel_hold", {awready, arready, wready, bvalid, rvalid, bresp, rresp}, 32'b110000000);

        // Prefill words 0..127 so every later read hits known content
        for (int i = 0; i < 128; i++) begin wbuf[i] = 16'($urandom); sbuf[i] = 2'b11; end
        do_write(16'h0000, 4'd1, 127, 3'd1, 2'b01, 0, resp);
        check("prefill_bresp", 32'(resp), 32'd0);

        // INCR write then read, id echo
        for (int i = 0; i < 4; i++) begin wbuf[i] = 16'h00A0 + 16'(i); sbuf[i] = 2'b11; end
        do_write(16'h0010, 4'd5, 3, 3'd1, 2'b01, 0, resp);
        check("incr_bresp", 32'(resp), 32'd0);
        do_read(16'h0010, 4'd5, 3, 3'd1, 2'b01, 0);
        for (int i = 0; i < 4; i++) check("incr_rdata", 32'(rbuf[i]), 32'h00A0 + 32'(i));
        check("incr_rresp", 32'(last_rresp), 32'd0);

        // Backpressure, then full-rate streaming
        do_read(16'h0020, 4'd2, 7, 3'd1, 2'b01, 1);
        do_read(16'h0020, 4'd2, 7, 3'd1, 2'b01, 0);
        check("stream_cycles", 32'(rcycles), 32'd8);

        // Byte strobes and FIXED bursts
        wbuf[0] = 16'hBEEF; sbuf[0] = 2'b11;
        do_write(16'h0080, 4'd3, 0, 3'd1, 2'b01, 0, resp);
        wbuf[0] = 16'h1234; sbuf[0] = 2'b01;
        do_write(16'h0080, 4'd3, 0, 3'd1, 2'b01, 0, resp);
        do_read(16'h0080, 4'd3, 0, 3'd1, 2'b01, 0);
        check("strb_merge", 32'(rbuf[0]), 32'hBE34);
        wbuf[0] = 16'h0011; wbuf[1] = 16'h0022; wbuf[2] = 16'h0033;
        sbuf[0] = 2'b11; sbuf[1] = 2'b11; sbuf[2] = 2'b11;
        do_write(16'h0082, 4'd4, 2, 3'd1, 2'b00, 0, resp);
        do_read(16'h0082, 4'd4, 0, 3'd1, 2'b01, 0);
        check("fixed_word", 32'(rbuf[0]), 32'h0033);

        // Legality / wlast table
        b_delay = 2;
        for (int k = 0; k < 9; k++) begin
            addr = 16'h00A0 + 16'(k * 8);
            w    = int'(addr >> 1);
            old  = model_mem[w];
            for (int i = 0; i <= vecs[k].len; i++) begin
                wbuf[i] = ~model_mem[(w + i) % DEPTH] ^ 16'(i << 4);
                sbuf[i] = 2'b11;
            end
            do_write(addr, 4'(k), vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].mode, resp);
            check("vec_bresp", 32'(resp), 32'(vecs[k].exp_bresp));
            do_read(addr, 4'(k), vecs[k].len, vecs[k].size, vecs[k].burst, 2);
            check("vec_rresp", 32'(last_rresp), 32'(vecs[k].exp_rresp));
            do_read(addr, 4'(k), 0, 3'd1, 2'b01, 0);
            check("vec_mem", 32'(rbuf[0]),
                  vecs[k].written ? 32'((vecs[k].burst == 2'b00) ? wbuf[vecs[k].len] : wbuf[0])
                                  : 32'(old));
        end
        b_delay = 0;

        // Reset in the middle of a read burst
        @(negedge clk);
        araddr = 16'h0020; arid = 4'd7; arlen = 8'd7; arsize = 3'd1; arburst = 2'b01;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        arvalid = 1'b0;
        rready  = 1'b1;
        n = 0;
        w = 0;
        while (w < 2 && n < 50) begin
            if (rvalid) w++;
            @(negedge clk);
            n++;
        end
        check("midrst_pre_valid", 32'(rvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_ready", {awready, arready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rvalid) extra++;
        end
        check("midrst_no_beats", 32'(extra), 32'd0);
        check("midrst_ready_back", {awready, arready}, 32'b11);
        rready = 1'b0;
        do_read(16'h0030, 4'd9, 0, 3'd1, 2'b01, 0);

        // Randomized traffic with address aliasing
        for (int it = 0; it < 40; it++) begin
            int          len, bsel;
            logic [1:0]  burst;
            logic [2:0]  size;
            w     = $urandom_range(0, 111);
            addr  = (16'($urandom) & 16'hF800) | 16'(w << 1) | 16'($urandom_range(0, 1));
            len   = $urandom_range(0, 15);
            bsel  = $urandom_range(0, 9);
            burst = (bsel < 4) ? 2'b00 : (bsel < 9) ? 2'b01 : 2'b10;
            size  = ($urandom_range(0, 9) == 0) ? 3'd0 : 3'd1;
            for (int i = 0; i <= len; i++) begin
                wbuf[i] = 16'($urandom);
                sbuf[i] = 2'($urandom);
            end
            b_delay = $urandom_range(0, 2);
            do_write(addr, 4'($urandom), len, size, burst,
                     ($urandom_range(0, 7) == 0) ? 1 : 0, resp);
            w    = $urandom_range(0, 111);
            addr = (16'($urandom) & 16'hF800) | 16'(w << 1);
            do_read(addr, 4'($urandom), $urandom_range(0, 15), 3'd1,
                    ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b01, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
